captura_de_comando: RTL and testbench

//   Input front-end for the two-user command panel: owns the raw switches (CH0..CH7)
//   and the active-low push-buttons (BTN0..BTN3), i.e. the input side of the panel

---
 rtl/captura_pkg.sv | 10 +
 rtl/filtro_de_entrada.sv | 31 +++
 rtl/captura_de_comando.sv | 74 +++++++
 tb/tb_captura_de_comando.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/captura_pkg.sv
// captura_pkg: shared command type and default timing for the command panel front-end
package captura_pkg;
  localparam int CMD_W = 6;
  localparam int DEB_CYCLES_DEF = 250000;
  localparam int CNT_W_DEF = 18;
  typedef struct packed {
    logic [2:0] user;
    logic [2:0] func;
  } cmd_t;
endpackage

// File: rtl/filtro_de_entrada.sv
// filtro_de_entrada: 2-flop synchroniser plus counter debounce for one panel input bit
module filtro_de_entrada
  import captura_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic REST       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);
  logic s1, s2, synced;
  logic [CNT_W-1:0] cnt;
  assign synced = s2 ^ REST;
  // two-stage synchroniser, parked at the input's rest level during reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2} <= {REST, REST};
    else {s1, s2} <= {raw, s1};
  // accept the synced level only after it has differed for DEB_CYCLES clocks in a row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) cnt <= '0;
    else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= synced;
      cnt    <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/captura_de_comando.sv
// captura_de_comando: debounced panel inputs turned into per-user command words with valid/ack
module captura_de_comando
  import captura_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ch,
  input  logic [3:0]       btn_n,
  output logic [2:0]       user0,
  output logic [2:0]       func0,
  output logic [2:0]       user1,
  output logic [2:0]       func1,
  output logic [CMD_W-1:0] cmd0,
  output logic [CMD_W-1:0] cmd1,
  output logic             cmd0_valid,
  output logic             cmd1_valid,
  input  logic             cmd0_ack,
  input  logic             cmd1_ack,
  output logic             cmd0_ovr,
  output logic             cmd1_ovr
);
  logic [11:0] raw, s;
  cmd_t w [2];
  cmd_t l [2];
  cmd_t cmd [2];
  logic [1:0] valid, ovr, ack;
  assign raw = {btn_n, ch};
  for (genvar i = 0; i < 12; i++) begin : g_filtro
    filtro_de_entrada #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W),
      .REST      (i >= 8)
    ) u_filtro (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .stable(s[i])
    );
  end
  assign w[0] = cmd_t'({s[0], s[1], s[2], s[3], s[8], s[9]});
  assign w[1] = cmd_t'({s[4], s[5], s[6], s[7], s[10], s[11]});
  assign ack  = {cmd1_ack, cmd0_ack};
  // per user: latch a changed word, flag an unacked overwrite, drop valid on ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        cmd[u] <= '0;
        l[u]   <= '0;
      end
      valid <= '0;
      ovr   <= '0;
    end else
      for (int u = 0; u < 2; u++)
        if (w[u] != l[u]) begin
          cmd[u]   <= w[u];
          l[u]     <= w[u];
          valid[u] <= 1'b1;
          ovr[u]   <= valid[u] & ~ack[u];
        end else begin
          ovr[u] <= 1'b0;
          if (valid[u] & ack[u]) valid[u] <= 1'b0;
        end
  assign {user0, func0} = w[0];
  assign {user1, func1} = w[1];
  assign cmd0       = cmd[0];
  assign cmd1       = cmd[1];
  assign cmd0_valid = valid[0];
  assign cmd1_valid = valid[1];
  assign cmd0_ovr   = ovr[0];
  assign cmd1_ovr   = ovr[1];
endmodule

// File: tb/tb_captura_de_comando.sv
// tb_captura_de_comando: directed table and sequence checks of the command capture front-end
module tb_captura_de_comando;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] ch = 8'hFF;
  logic [3:0] btn_n = 4'h0;
  logic [2:0] user0, func0, user1, func1;
  logic [5:0] cmd0, cmd1;
  logic cmd0_valid, cmd1_valid, cmd0_ack = 1'b0, cmd1_ack = 1'b0, cmd0_ovr, cmd1_ovr;
  int passed = 0, total = 0;

  typedef struct {
    logic [7:0] ch;
    logic [3:0] btn_n;
    logic a0, a1;
    int cyc;
    logic [2:0] u0, f0, u1, f1;
    logic [5:0] c0, c1;
    logic v0, v1, o0, o1;
  } vec_t;
  vec_t tbl [6];

  captura_de_comando #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ch(ch), .btn_n(btn_n),
    .user0(user0), .func0(func0), .user1(user1), .func1(func1),
    .cmd0(cmd0), .cmd1(cmd1), .cmd0_valid(cmd0_valid), .cmd1_valid(cmd1_valid),
    .cmd0_ack(cmd0_ack), .cmd1_ack(cmd1_ack), .cmd0_ovr(cmd0_ovr), .cmd1_ovr(cmd1_ovr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic ack_both();
    cmd0_ack = 1'b1;
    cmd1_ack = 1'b1;
    step();
    cmd0_ack = 1'b0;
    cmd1_ack = 1'b0;
  endtask

  initial begin
    int glitch;
    // reset with every input away from rest
    repeat (3) step();
    chk("rst_user0", user0, 0);
    chk("rst_func0", func0, 0);
    chk("rst_user1", user1, 0);
    chk("rst_cmd0", cmd0, 0);
    chk("rst_cmd1", cmd1, 0);
    chk("rst_valid", {cmd0_valid, cmd1_valid}, 0);
    chk("rst_ovr", {cmd0_ovr, cmd1_ovr}, 0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("rel_user0_e5", user0, 0);
    step();
    chk("rel_user0_e6", user0, 7);
    chk("rel_func0_e6", func0, 7);
    chk("rel_valid0_e6", cmd0_valid, 0);
    step();
    chk("rel_valid0_e7", cmd0_valid, 1);
    chk("rel_cmd0_e7", cmd0, 6'h3F);
    chk("rel_valid1_e7", cmd1_valid, 1);
    chk("rel_cmd1_e7", cmd1, 6'h3F);
    chk("rel_ovr0_e7", cmd0_ovr, 0);
    ack_both();
    chk("rel_ack_valid", {cmd0_valid, cmd1_valid}, 0);
    // return to neutral is itself a command
    ch = 8'h00;
    btn_n = 4'hF;
    repeat (7) step();
    chk("neutral_cmd0", cmd0, 0);
    chk("neutral_valid0", cmd0_valid, 1);
    ack_both();
    chk("neutral_ack", cmd0_valid, 0);

    // exact latency of ch[0],ch[2]
    ch = 8'h05;
    repeat (5) step();
    chk("lat_user0_e5", user0, 0);
    step();
    chk("lat_user0_e6", user0, 5);
    chk("lat_valid0_e6", cmd0_valid, 0);
    step();
    chk("lat_valid0_e7", cmd0_valid, 1);
    chk("lat_cmd0_e7", cmd0, 6'b101000);
    chk("lat_valid1_e7", cmd1_valid, 0);

    // overwrite while pending and unacked
    btn_n = 4'b1101;
    repeat (6) step();
    chk("ovr_e6_ovr", cmd0_ovr, 0);
    chk("ovr_e6_cmd", cmd0, 6'b101000);
    step();
    chk("ovr_e7_ovr", cmd0_ovr, 1);
    chk("ovr_e7_cmd", cmd0, 6'b101001);
    chk("ovr_e7_valid", cmd0_valid, 1);
    step();
    chk("ovr_e8_ovr", cmd0_ovr, 0);
    chk("ovr_e8_valid", cmd0_valid, 1);

    // single-cycle ack
    cmd0_ack = 1'b1;
    step();
    cmd0_ack = 1'b0;
    chk("ack_valid0", cmd0_valid, 0);
    chk("ack_cmd0", cmd0, 6'b101001);
    chk("ack_valid1", cmd1_valid, 0);
    chk("ack_user1", user1, 0);

    // 3-cycle glitch on btn_n[0]
    glitch = 0;
    btn_n = 4'b1100;
    repeat (3) begin
      step();
      if (func0 != 3'b001 || cmd0_valid || cmd0_ovr) glitch++;
    end
    btn_n = 4'b1101;
    repeat (8) begin
      step();
      if (func0 != 3'b001 || cmd0_valid || cmd0_ovr) glitch++;
    end
    chk("glitch_events", glitch, 0);

    // ack on the same edge a new word commits
    ch = 8'h0D;
    repeat (7) step();
    chk("same_pre_valid", cmd0_valid, 1);
    chk("same_pre_cmd", cmd0, 6'b101101);
    ch = 8'h0F;
    repeat (6) step();
    cmd0_ack = 1'b1;
    step();
    cmd0_ack = 1'b0;
    chk("same_valid", cmd0_valid, 1);
    chk("same_cmd", cmd0, 6'b111101);
    chk("same_ovr", cmd0_ovr, 0);
    step();
    chk("same_valid_hold", cmd0_valid, 1);
    cmd0_ack = 1'b1;
    step();
    cmd0_ack = 1'b0;
    chk("same_cleared", cmd0_valid, 0);

    // both users commit on the same edge
    ch = 8'h1F;
    btn_n = 4'b1100;
    repeat (6) step();
    chk("both_e6_valid", {cmd0_valid, cmd1_valid}, 0);
    step();
    chk("both_e7_valid", {cmd0_valid, cmd1_valid}, 3);
    chk("both_cmd0", cmd0, 6'h3F);
    chk("both_cmd1", cmd1, 6'b100000);
    chk("both_ovr", {cmd0_ovr, cmd1_ovr}, 0);
    ack_both();

    // reset while a debounce counter sits at 2
    ch = 8'h9F;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_user1", user1, 0);
    chk("mid_rst_cmd0", cmd0, 0);
    chk("mid_rst_valid", {cmd0_valid, cmd1_valid}, 0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("mid_rst_user1_e5", user1, 0);
    step();
    chk("mid_rst_user1_e6", user1, 4);
    chk("mid_rst_func1_e6", func1, 4);
    step();
    chk("mid_rst_valid1", cmd1_valid, 1);
    chk("mid_rst_cmd1", cmd1, 6'b100100);
    chk("mid_rst_valid0", cmd0_valid, 1);
    chk("mid_rst_cmd0_e7", cmd0, 6'h3F);

    // plateau vectors from the state above
    tbl[0] = '{8'h9F, 4'hC, 1'b1, 1'b1, 1, 3'd7, 3'd7, 3'd4, 3'd4, 6'h3F, 6'h24, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h9F, 4'hC, 1'b1, 1'b1, 2, 3'd7, 3'd7, 3'd4, 3'd4, 6'h3F, 6'h24, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 4'hF, 1'b0, 1'b0, 8, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h50, 4'hF, 1'b1, 1'b0, 8, 3'd0, 3'd0, 3'd5, 3'd0, 6'h00, 6'h28, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h50, 4'h3, 1'b0, 1'b1, 8, 3'd0, 3'd0, 3'd5, 3'd3, 6'h00, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 4'hF, 1'b0, 1'b0, 8, 3'd4, 3'd0, 3'd0, 3'd0, 6'h20, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      ch = tbl[i].ch;
      btn_n = tbl[i].btn_n;
      cmd0_ack = tbl[i].a0;
      cmd1_ack = tbl[i].a1;
      repeat (tbl[i].cyc) step();
      cmd0_ack = 1'b0;
      cmd1_ack = 1'b0;
      chk($sformatf("vec%0d_user0", i), user0, tbl[i].u0);
      chk($sformatf("vec%0d_func0", i), func0, tbl[i].f0);
      chk($sformatf("vec%0d_user1", i), user1, tbl[i].u1);
      chk($sformatf("vec%0d_func1", i), func1, tbl[i].f1);
      chk($sformatf("vec%0d_cmd0", i), cmd0, tbl[i].c0);
      chk($sformatf("vec%0d_cmd1", i), cmd1, tbl[i].c1);
      chk($sformatf("vec%0d_valid0", i), cmd0_valid, tbl[i].v0);
      chk($sformatf("vec%0d_valid1", i), cmd1_valid, tbl[i].v1);
      chk($sformatf("vec%0d_ovr0", i), cmd0_ovr, tbl[i].o0);
      chk($sformatf("vec%0d_ovr1", i), cmd1_ovr, tbl[i].o1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
